log_capture_ctrl: RTL and testbench
===================================

// Module: log_capture_ctrl
// PURPOSE
//  Sequencer for the sample-log memory behind the micro register bank. A one-cycle run
//  pulse arms a capture that writes one word per valid sample until the memory holds
//  2**NB_ADDR words, then flags full. After that the micro reads words back by address.
//  Sits between the Rx datapath tap, the log RAM and the register bank run/read/addr/full lines.
// PARAMETERS
//  NB_DATA   32   width of one logged word (matches micro data path)
//  NB_ADDR   15   log address width; DEPTH = 2**NB_ADDR = 32768 words
// PORTS
//  clock          in   1        system clock; all logic on rising edge
//  reset          in   1        synchronous, active-high
//  i_run_log      in   1        one-cycle pulse: (re)start capture from address 0
//  i_sample       in   NB_DATA  word to log
//  i_sample_valid in   1        i_sample valid this cycle
//  i_read_log     in   1        level: readback enabled
//  i_addr_log     in   NB_ADDR  readback address
//  o_mem_full     out  1        capture complete, memory readable
//  o_busy         out  1        capture in progress
//  o_data_log     out  NB_DATA  readback word
//  o_data_valid   out  1        one-cycle pulse: o_data_log updated
// BEHAVIOUR
//  Reset is synchronous, active-high, on clock. Reset values: o_mem_full=0, o_busy=0,
//   o_data_log=0, o_data_valid=0, wr_ptr=0, state=IDLE. RAM contents are not cleared.
//  FSM states: IDLE, CAPTURE, FULL.
//   IDLE    -> CAPTURE on i_run_log.
//   CAPTURE: each i_sample_valid writes i_sample to ram[wr_ptr] and increments wr_ptr.
//            The write at wr_ptr=DEPTH-1 moves to FULL; o_mem_full=1 from the next cycle.
//   FULL:    holds until i_run_log or reset. Further samples are ignored.
//  i_run_log in any state clears o_mem_full and wr_ptr and enters CAPTURE next cycle.
//   A sample valid in the same cycle as i_run_log is discarded (run has priority).
//  o_busy = (state==CAPTURE). wr_ptr is NB_ADDR+1 bits wide, so it never wraps silently.
//  Readback occurs only in FULL with i_read_log=1. RAM read is synchronous.
//   o_data_log = ram[i_addr_log sampled at edge T], valid after edge T+1.
//   o_data_valid pulses at T+1. Latency is 1 clock; back-to-back addresses give one word per clock.
//  A read request outside FULL is ignored: o_data_log holds its value and no valid pulse is produced.
//  Reset during CAPTURE aborts the capture to IDLE. Partial data stays in the RAM but is
//   unreadable until the next full capture.
//  A write and a read never coincide, because reads are gated by FULL and writes by CAPTURE.
// STRUCTURE
//  Shared package holds: state encodings (IDLE=2'd0, CAPTURE=2'd1, FULL=2'd2),
//   NB_LOG_ADDR=15 and NB_LOG_DATA=32.
//  Sub-module log_ram: simple dual-port RAM, one write port, one sync-read port,
//   DEPTH x NB_DATA, inferred as block RAM.
//  Top level holds the FSM, the write pointer, the read gating and the output registers.
// TESTING
//  1 Reset -> o_mem_full=0, o_busy=0, o_data_log=0, o_data_valid=0. Reads ignored.
//  2 i_run_log pulse, then 32768 valid samples with value = index -> o_busy=1 throughout;
//    o_mem_full=1 one cycle after the last write; a 32769th sample is not stored.
//  3 In FULL, i_read_log=1 with addr 0x0005 then 0x7FFF on consecutive clocks ->
//    o_data_log=5 then 32767, each one clock after its address, each with o_data_valid.
//  4 i_run_log after 100 captured samples -> wr_ptr restarts; full only after 32768 more
//    samples; readback at addr 0 returns the first post-restart sample.
//  5 Reset asserted at sample 1000 -> IDLE, o_busy=0, o_mem_full=0; a read at addr 0
//    produces no valid pulse and o_data_log stays 0.
//  6 i_run_log and i_sample_valid (value 0xDEAD) in the same cycle, next sample 0xBEEF
//    -> after full, ram[0]=0xBEEF.

Source files
------------

// File: rtl/log_capture_ctrl_pkg.sv
// Shared definitions for the sample-log capture sequencer: FSM state
// encodings, default widths and a depth helper.
package log_capture_ctrl_pkg;

  localparam int NB_LOG_ADDR = 15;
  localparam int NB_LOG_DATA = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } log_state_t;

  // Number of words held by a log memory with nb_addr address bits.
  function automatic int unsigned log_depth(input int unsigned nb_addr);
    return 32'd1 << nb_addr;
  endfunction

endpackage

// File: rtl/log_capture_ctrl_if.sv
// Capture/readback bus between the register bank / Rx tap side (master)
// and the log capture sequencer (slave).
interface log_capture_ctrl_if
  import log_capture_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) ();

  logic               i_run_log;
  logic [NB_DATA-1:0] i_sample;
  logic               i_sample_valid;
  logic               i_read_log;
  logic [NB_ADDR-1:0] i_addr_log;
  logic               o_mem_full;
  logic               o_busy;
  logic [NB_DATA-1:0] o_data_log;
  logic               o_data_valid;

  modport master (
    output i_run_log, i_sample, i_sample_valid, i_read_log, i_addr_log,
    input  o_mem_full, o_busy, o_data_log, o_data_valid
  );

  modport slave (
    input  i_run_log, i_sample, i_sample_valid, i_read_log, i_addr_log,
    output o_mem_full, o_busy, o_data_log, o_data_valid
  );

endinterface

// File: rtl/log_capture_ctrl_log_ram.sv
// Simple dual-port log RAM: one write port, one synchronous read port with a
// resettable output register (maps onto a block RAM output latch reset).
module log_ram
  import log_capture_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic               rd_en,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem [0:log_depth(NB_ADDR)-1];

  // Write port: contents are never cleared.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-clock latency, output holds when not enabled.
  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/log_capture_ctrl.sv
// Sample-log sequencer: a run pulse arms a capture of one word per valid
// sample until the RAM is full; afterwards the micro reads words by address.
module log_capture_ctrl
  import log_capture_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_LOG_DATA,
  parameter int NB_ADDR = NB_LOG_ADDR
) (
  input  logic                clock,
  input  logic                reset,
  log_capture_ctrl_if.slave   log_bus
);

  localparam logic [NB_ADDR:0] LAST_ADDR = {1'b0, {NB_ADDR{1'b1}}};

  log_state_t       state;
  log_state_t       state_next;
  logic [NB_ADDR:0] wr_ptr;
  logic [NB_ADDR:0] wr_ptr_next;
  logic             wr_en;
  logic             rd_en;
  logic             data_valid;

  // State, write pointer and readback-valid registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr_next;
      data_valid <= rd_en;
    end
  end

  // Next state and write control; a run pulse outranks a same-cycle sample.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    wr_en       = 1'b0;
    if (log_bus.i_run_log) begin
      state_next  = CAPTURE;
      wr_ptr_next = '0;
    end else begin
      case (state)
        IDLE: ;
        CAPTURE: begin
          if (log_bus.i_sample_valid) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) state_next = FULL;
          end
        end
        FULL: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // Reads only in FULL, writes only in CAPTURE: the ports never collide.
  assign rd_en = (state == FULL) && log_bus.i_read_log;

  log_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_log_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[NB_ADDR-1:0]),
    .wr_data (log_bus.i_sample),
    .rd_en   (rd_en),
    .rd_addr (log_bus.i_addr_log),
    .rd_data (log_bus.o_data_log)
  );

  assign log_bus.o_busy       = (state == CAPTURE);
  assign log_bus.o_mem_full   = (state == FULL);
  assign log_bus.o_data_valid = data_valid;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Bench for log_capture_ctrl: a word-level model of the log (array + count +
// full/capturing flags) is compared every cycle, plus literal spot checks.
module tb_log_capture_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 15;
  localparam int DEPTH   = 1 << NB_ADDR;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  log_capture_ctrl_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  log_capture_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock   (clock),
    .reset   (reset),
    .log_bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: what the log must hold and show, from the capture/readback rules.
  logic [31:0] m_mem [DEPTH];
  int          m_count;
  bit          m_capturing, m_full, m_valid, model_live = 1'b0;
  logic [31:0] m_data;

  always @(posedge clock) begin
    if (reset) begin
      m_count     <= 0;
      m_capturing <= 1'b0;
      m_full      <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      model_live  <= 1'b1;
    end else if (model_live) begin
      m_valid <= 1'b0;
      if (m_full && bus.i_read_log) begin
        m_data  <= m_mem[bus.i_addr_log];
        m_valid <= 1'b1;
      end
      if (bus.i_run_log) begin
        m_count     <= 0;
        m_full      <= 1'b0;
        m_capturing <= 1'b1;
      end else if (m_capturing && bus.i_sample_valid) begin
        m_mem[m_count] <= bus.i_sample;
        m_count        <= m_count + 1;
        if (m_count == DEPTH - 1) begin
          m_capturing <= 1'b0;
          m_full      <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_live) begin
      check("busy",  {31'd0, bus.o_busy},       {31'd0, m_capturing});
      check("full",  {31'd0, bus.o_mem_full},   {31'd0, m_full});
      check("valid", {31'd0, bus.o_data_valid}, {31'd0, m_valid});
      check("data",  bus.o_data_log,            m_data);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic read_word(input logic [14:0] addr, input logic [31:0] exp, input string name);
    bus.i_read_log = 1'b1;
    bus.i_addr_log = addr;
    tick();
    check({name, "_data"}, bus.o_data_log, exp);
    check({name, "_valid"}, {31'd0, bus.o_data_valid}, 32'd1);
  endtask

  // Watchdog: the sequence below is fixed-length; this only guards a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    bus.i_run_log      = 1'b0;
    bus.i_sample       = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_read_log     = 1'b0;
    bus.i_addr_log     = '0;
    repeat (3) tick();
    reset = 1'b0;

    // 1: reset state, reads ignored outside FULL
    check("rst_full",  {31'd0, bus.o_mem_full},   32'd0);
    check("rst_busy",  {31'd0, bus.o_busy},       32'd0);
    check("rst_data",  bus.o_data_log,            32'd0);
    check("rst_valid", {31'd0, bus.o_data_valid}, 32'd0);
    bus.i_read_log = 1'b1;
    repeat (3) tick();
    check("idle_rd_valid", {31'd0, bus.o_data_valid}, 32'd0);
    check("idle_rd_data",  bus.o_data_log,            32'd0);
    bus.i_read_log = 1'b0;

    // 5: reset after 1000 samples aborts the capture
    bus.i_run_log = 1'b1;
    tick();
    bus.i_run_log = 1'b0;
    check("abort_busy_on", {31'd0, bus.o_busy}, 32'd1);
    bus.i_sample_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.i_sample = 32'h5000 + i;
      tick();
    end
    bus.i_sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.o_busy},     32'd0);
    check("abort_full", {31'd0, bus.o_mem_full}, 32'd0);
    bus.i_read_log = 1'b1;
    bus.i_addr_log = '0;
    repeat (2) tick();
    check("abort_rd_valid", {31'd0, bus.o_data_valid}, 32'd0);
    check("abort_rd_data",  bus.o_data_log,            32'd0);
    bus.i_read_log = 1'b0;

    // 2: full capture of value = index, then one surplus sample
    bus.i_run_log = 1'b1;
    tick();
    bus.i_run_log = 1'b0;
    bus.i_sample_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_sample = i;
      if (i == 0)         check("cap_busy_first", {31'd0, bus.o_busy}, 32'd1);
      if (i == DEPTH - 1) begin
        check("cap_busy_last",     {31'd0, bus.o_busy},     32'd1);
        check("cap_full_not_yet",  {31'd0, bus.o_mem_full}, 32'd0);
      end
      tick();
    end
    check("cap_full",      {31'd0, bus.o_mem_full}, 32'd1);
    check("cap_busy_done", {31'd0, bus.o_busy},     32'd0);
    bus.i_sample = 32'hFFFF_FFFF;
    tick();
    bus.i_sample_valid = 1'b0;

    // 3: back-to-back readback, surplus sample must not have landed at 0
    read_word(15'h0005, 32'd5,     "rd_5");
    read_word(15'h7FFF, 32'd32767, "rd_7fff");
    read_word(15'h0000, 32'd0,     "rd_0");
    bus.i_read_log = 1'b0;
    tick();
    check("rd_off_valid", {31'd0, bus.o_data_valid}, 32'd0);
    check("rd_off_hold",  bus.o_data_log,            32'd0);
    bus.i_read_log = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.i_addr_log = 15'((i * 517 + 3) % DEPTH);
      tick();
    end
    bus.i_read_log = 1'b0;
    tick();

    // 4 + 6: restart after 100 samples; run with 0xDEAD sample discards it
    bus.i_run_log = 1'b1;
    tick();
    bus.i_run_log = 1'b0;
    bus.i_sample_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.i_sample = 32'hA000 + i;
      tick();
    end
    bus.i_run_log = 1'b1;
    bus.i_sample  = 32'hDEAD;
    tick();
    bus.i_run_log = 1'b0;
    check("restart_busy", {31'd0, bus.o_busy},     32'd1);
    check("restart_full", {31'd0, bus.o_mem_full}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 7 == 3) begin
        bus.i_sample_valid = 1'b0;
        bus.i_sample       = 32'hBAD0_0000;
        tick();
      end
      bus.i_sample_valid = 1'b1;
      bus.i_sample       = (i == 0) ? 32'hBEEF : 32'h10000 + i;
      if (i == DEPTH - 1) check("re_full_not_yet", {31'd0, bus.o_mem_full}, 32'd0);
      tick();
    end
    bus.i_sample_valid = 1'b0;
    check("re_full", {31'd0, bus.o_mem_full}, 32'd1);
    read_word(15'h0000, 32'hBEEF,  "re_rd_0");
    read_word(15'h0001, 32'h10001, "re_rd_1");
    read_word(15'd99,   32'h10063, "re_rd_99");
    bus.i_read_log = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
